// File: rtl/reg_file_rw.sv
// Register bank with two combinational read ports, one write port, r0 tied to 0,
// and a soft-clear sequencer. Define RF_BYPASS_EN for same-cycle write-through reads.
module reg_file_rw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    input  logic                  clr_req,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  busy,
    output logic                  clr_done
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg;
    logic [ADDR_WIDTH-1:0]   cnt_next;
    logic                    wr_fire;
    logic                    clr_active;
    logic [DATA_WIDTH-1:0]   rf_q [NUM_REGS];

    // A write only lands in IDLE with no clear request; a clear request wins.
    assign wr_fire    = (state_reg == IDLE) && !clr_req && reg_write && (write_reg != '0);
    assign clr_active = (state_reg == CLEAR);
    assign busy       = clr_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= FIRST_IDX;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clr_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = FIRST_IDX;
                end
            end
            CLEAR: begin
                // Terminal compare keeps the counter from wrapping onto r0.
                if (cnt_reg == LAST_IDX) begin
                    state_next = IDLE;
                    cnt_next   = FIRST_IDX;
                    clr_done   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + FIRST_IDX;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = FIRST_IDX;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_store
                logic [DATA_WIDTH-1:0] q_reg;
                logic                  clr_hit;
                logic                  wr_hit;

                assign clr_hit = clr_active && (cnt_reg == ADDR_WIDTH'(gi));
                assign wr_hit  = wr_fire && (write_reg == ADDR_WIDTH'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (clr_hit) begin
                        q_reg <= '0;
                    end else if (wr_hit) begin
                        q_reg <= write_data;
                    end
                end

                assign rf_q[gi] = q_reg;
            end
        end
    endgenerate

`ifdef RF_BYPASS_EN
    // wr_fire already excludes index 0, so r0 still reads 0 when forwarded.
    assign read_data1 = (wr_fire && (write_reg == read_reg1)) ? write_data : rf_q[read_reg1];
    assign read_data2 = (wr_fire && (write_reg == read_reg2)) ? write_data : rf_q[read_reg2];
`else
    assign read_data1 = rf_q[read_reg1];
    assign read_data2 = rf_q[read_reg2];
`endif

endmodule

// File: tb/tb_reg_file_rw.sv
// Self-checking bench for reg_file_rw: directed steps then randomized traffic
// compared against an array-based reference model.
module tb_reg_file_rw;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic        clr_req;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        busy;
    logic        clr_done;

    int tests_run;
    int tests_failed;

    // Reference model: register contents plus number of clear cycles still to run.
    logic [31:0] m_regs [32];
    int          m_left;

    reg_file_rw #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .clr_req    (clr_req),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .busy       (busy),
        .clr_done   (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_left = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (m_left == 0 && reg_write && !clr_req && write_reg == idx) return write_data;
`endif
        return m_regs[idx];
    endfunction

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                         input logic [31:0] wd, input logic we, input logic clr);
        read_reg1  = r1;
        read_reg2  = r2;
        write_reg  = wr;
        write_data = wd;
        reg_write  = we;
        clr_req    = clr;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".rd1"}, read_data1, exp_read(read_reg1));
        chk({tag, ".rd2"}, read_data2, exp_read(read_reg2));
        chk({tag, ".busy"}, {31'b0, busy}, {31'b0, (m_left != 0)});
        chk({tag, ".done"}, {31'b0, clr_done}, {31'b0, (m_left == 1)});
    endtask

    // Advance one clock and apply the architectural effect of the sampled inputs.
    task automatic tick();
        @(posedge clk);
        if (m_left != 0) begin
            m_regs[32 - m_left] = '0;
            m_left--;
        end else if (clr_req) begin
            m_left = 31;
        end else if (reg_write && write_reg != 5'd0) begin
            m_regs[write_reg] = write_data;
        end
        #1;
    endtask

    task automatic cycle(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                         input logic [31:0] wd, input logic we, input logic clr, input string tag);
        drive(r1, r2, wr, wd, we, clr);
        check_all(tag);
        tick();
    endtask

    int busy_cnt;
    int done_cnt;
    int done_on_last;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Step 1: reset state
        #12;
        drive(5'd5, 5'd31, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all("reset");
        rst_n = 1'b1;
        #1;
        check_all("post_reset");
        tick();

        // Step 2: two writes then read back
        cycle(5'd8, 5'd9, 5'd8, 32'hA5A5A5A5, 1'b1, 1'b0, "wr_r8");
        cycle(5'd8, 5'd9, 5'd9, 32'hDEADBEEF, 1'b1, 1'b0, "wr_r9");
        drive(5'd8, 5'd9, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rd_r8_const", read_data1, 32'hA5A5A5A5);
        chk("rd_r9_const", read_data2, 32'hDEADBEEF);
        tick();

        // Step 3: write to r0 is discarded
        cycle(5'd0, 5'd0, 5'd0, 32'h12345678, 1'b1, 1'b0, "wr_r0");
        drive(5'd0, 5'd8, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rd_r0_const", read_data1, 32'h0);
        tick();

        // Step 4: fill, clear with a dropped write inside the window
        for (int i = 1; i < 32; i++)
            cycle(5'(i), 5'(32 - i), 5'(i), 32'h87654321, 1'b1, 1'b0, "fill");
        busy_cnt     = 0;
        done_cnt     = 0;
        done_on_last = 0;
        for (int i = 0; i < 40; i++) begin
            drive(5'(i % 32), 5'd31, 5'd31, 32'h0000FFFF, (i == 5), (i == 0));
            check_all("clear");
            if (busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                if (busy_cnt == 31) done_on_last = 1;
            end
            tick();
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd31);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("done_on_last", 32'(done_on_last), 32'd1);
        for (int i = 1; i < 32; i++) begin
            drive(5'(i), 5'(i), 5'd0, 32'h0, 1'b0, 1'b0);
            #1;
            chk("after_clear", read_data1, 32'h0);
        end
        tick();

        // Step 5: asynchronous reset in the middle of a clear
        for (int i = 1; i < 32; i++)
            cycle(5'(i), 5'd1, 5'(i), $urandom, 1'b1, 1'b0, "fill2");
        cycle(5'd1, 5'd2, 5'd0, 32'h0, 1'b0, 1'b1, "clr2");
        for (int i = 0; i < 10; i++)
            cycle(5'd30, 5'd20, 5'd0, 32'h0, 1'b0, 1'b0, "clr2_run");
        rst_n = 1'b0;
        model_reset();
        drive(5'd30, 5'd31, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all("mid_rst");
        chk("mid_rst_busy_const", {31'b0, busy}, 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            drive(5'(i), 5'(32 - i), 5'd0, 32'h0, 1'b0, 1'b0);
            #1;
            chk("rst_zero", read_data1, 32'h0);
        end
        tick();
        cycle(5'd3, 5'd0, 5'd3, 32'h00000042, 1'b1, 1'b0, "wr_r3");
        drive(5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rd_r3_const", read_data1, 32'h00000042);
        tick();

        // Step 6: same-cycle write and read of r4
        drive(5'd0, 5'd4, 5'd4, 32'hCAFEF00D, 1'b1, 1'b0);
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_r4", read_data2, 32'hCAFEF00D);
`else
        chk("nobypass_r4", read_data2, 32'h0);
`endif
        tick();
        drive(5'd0, 5'd4, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("r4_next", read_data2, 32'hCAFEF00D);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4:0] wr;
            logic [4:0] r1;
            logic [4:0] r2;
            wr = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cycle(r1, r2, wr, $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 59) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
